// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

    // A single-nibble datapath still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        int n;
        n = num_nibbles(width);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUM_NIBBLES = num_nibbles(DEFAULT_WIDTH);
    localparam int IDX_W       = idx_width(DEFAULT_WIDTH);

endpackage

// File: rtl/nibble_serial_subtractor_sub4.sv
// Combinational 4-bit slice: diff = a - b - bin, with unsigned borrow out.
module subtractor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [4:0] wide;

    assign wide = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    assign diff = wide[3:0];
    assign bout = wide[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial subtractor: one nibble per clock through a single 4-bit slice,
// IDLE -> RUN (WIDTH/4 cycles) -> DONE, with back-to-back restart from DONE.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIBS     = num_nibbles(WIDTH);
    localparam int IDX_BITS = idx_width(WIDTH);

    state_e                state_q;
    logic [WIDTH-1:0]      a_q, b_q, diff_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic                  borrow_q, bout_q, ovf_q, zero_q;

    logic [NIBBLE_W-1:0]   a_nib, b_nib, slice_diff;
    logic                  slice_bout;
    logic [WIDTH-1:0]      diff_d;
    logic                  last_nib;
    logic                  ovf_d, zero_d;

    always_comb begin
        a_nib    = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        b_nib    = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        diff_d   = diff_q;
        diff_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = slice_diff;
        last_nib = (idx_q == IDX_BITS'(NIBS - 1));
        // Flags are taken from the result including the nibble finishing this cycle.
        ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
        zero_d   = (diff_d == '0);
    end

    subtractor_4bit u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .bin  (borrow_q),
        .diff (slice_diff),
        .bout (slice_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        idx_q    <= '0;
                        borrow_q <= bin;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= slice_bout;
                    if (last_nib) begin
                        idx_q   <= '0;
                        bout_q  <= slice_bout;
                        ovf_q   <= ovf_d;
                        zero_q  <= zero_d;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed vector table, multi-cycle corner sequences and a random
// scoreboard for the nibble-serial subtractor (WIDTH = 16).
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, ovf, zero;
    logic [15:0] diff;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start one operation and wait for done; lat counts negedge samples after E0.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        bin   = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [18:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                               input logic bi);
        logic [16:0] w;
        logic        o;
        w = {1'b0, a} - {1'b0, b} - {16'h0000, bi};
        o = (a[15] != b[15]) && (w[15] != a[15]);
        return {w[15:0], w[16], o, (w[15:0] == 16'h0000)};
    endfunction

    initial begin
        int lat, bc;
        logic seen_done;
        logic [15:0] ra, rb;
        logic rbi;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, diff, bout, ovf, zero}, '0);
        rst_n = 1'b1;

        // Latency, busy width, done pulse width and result hold
        do_op(16'h1234, 16'h0234, 1'b0, lat, bc);
        check("latency", lat, 5);
        check("busy_cycles", bc, 4);
        check("first_result", {diff, bout, ovf, zero}, {16'h1000, 3'b000});
        @(negedge clk);
        check("done_one_cycle", {done, busy}, 2'b00);
        check("result_hold", {diff, bout, ovf, zero}, {16'h1000, 3'b000});

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat, bc);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_result", i), {diff, bout, ovf, zero},
                  {vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z});
        end

        // start during RUN with different operands is ignored
        @(negedge clk);
        in_a = 16'h1111; in_b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        in_a = 16'h2222; in_b = 16'h0222; bin = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("run_start_latency", lat, 5);
        check("run_start_ignored", {diff, bout, ovf, zero}, {16'h1110, 3'b000});

        // start held in DONE: back-to-back with no IDLE cycle
        do_op(16'h1234, 16'h0234, 1'b0, lat, bc);
        in_a = 16'h8000; in_b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle", {busy, done}, 2'b10);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency", lat, 5);
        check("b2b_result", {diff, bout, ovf, zero}, {16'h7FFF, 3'b010});

        // Reset during the 2nd RUN cycle aborts the operation
        @(negedge clk);
        in_a = 16'h00FF; in_b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {busy, done, diff, bout, ovf, zero}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("no_done_after_abort", seen_done, 1'b0);
        do_op(16'h00FF, 16'h0001, 1'b0, lat, bc);
        check("post_reset_latency", lat, 5);
        check("post_reset_result", {diff, bout, ovf, zero}, {16'h00FE, 3'b000});

        // Random scoreboard
        for (int k = 0; k < 10000; k++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            do_op(ra, rb, rbi, lat, bc);
            check($sformatf("rand%0d %h-%h-%0d", k, ra, rb, rbi),
                  {lat[3:0], diff, bout, ovf, zero}, {4'd5, ref_result(ra, rb, rbi)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled on rising clk.
REQ-005 in_a  input  WIDTH  minuend.
REQ-006 in_b  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow in.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse; result and flags valid.
REQ-010 diff  output  WIDTH  in_a - in_b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  unsigned borrow out; 1 iff in_a < in_b + bin.
REQ-012 ovf  output  1  two's-complement overflow.
REQ-013 zero  output  1  1 iff diff == 0.

Function
REQ-014 States SHALL be IDLE, RUN and DONE; busy = (state == RUN); done = (state == DONE).
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch in_a, in_b and bin, set nibble index to 0, load the borrow register with bin, and enter RUN.
REQ-016 In RUN, each edge SHALL compute one 4-bit slice: diff[4i+3:4i] = a_nib - b_nib - borrow; the borrow register SHALL take that slice's borrow out; the index SHALL increment.
REQ-017 The edge that processes the last nibble (index WIDTH/4-1) SHALL update bout, ovf and zero from the completed result and enter DONE.
REQ-018 Latency: start is sampled at edge E0, slices are processed at E1 to E4 (WIDTH=16), and done is high for exactly the cycle after E4.
REQ-019 From DONE, the next edge SHALL go to IDLE when start=0, or to RUN with new operands when start=1 (back-to-back operation, no dead cycle).
REQ-020 start in RUN SHALL be ignored; latched operands SHALL NOT change while busy.
REQ-021 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
REQ-022 diff, bout, ovf and zero SHALL hold their last values from DONE until the next RUN begins.
REQ-023 diff nibbles not yet processed during RUN are don't-care; consumers SHALL sample only when done=1.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE; busy, done, diff, bout, ovf, zero, index and borrow SHALL all be 0.
REQ-025 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-026 After rst_n deasserts, the first edge with start=1 SHALL behave per REQ-015.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE/RUN/DONE), NIBBLE_W=4, and the derived NUM_NIBBLES=WIDTH/4 and index width.
REQ-028 The per-cycle slice SHALL be one combinational sub-module, subtractor_4bit (a, b, bin -> diff, bout), instantiated once.
REQ-029 The datapath SHALL contain exactly one 4-bit slice; no full-width subtractor.

Verification
REQ-030 in_a=0x1234, in_b=0x0234, bin=0 -> done at E0+5; diff=0x1000, bout=0, ovf=0, zero=0; busy high for exactly 4 cycles.
REQ-031 in_a=0x0000, in_b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; in_a=0x8000, in_b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
REQ-032 in_a=0x5555, in_b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0.
REQ-033 start during RUN with different operands -> ignored; the original result is reported. start held high in DONE -> second result follows 5 cycles later with no IDLE cycle.
REQ-034 rst_n pulsed low during the 2nd RUN cycle -> all outputs 0 asynchronously, no done pulse; the next start produces a correct result.
REQ-035 Random scoreboard of 10k operations against the reference a-b-bin, checking diff, bout, ovf and zero.
